// File: rtl/mbist_march_if.sv
// ---------------------------------------------------------------------------
// mbist_march_if
// Bus between the March C- BIST controller and the memory under test.
//   mem_write_read : 1 = write, 0 = read (controller -> memory)
//   mem_address    : word address                  (controller -> memory)
//   mem_wdata      : write data, presented one cycle ahead of the write
//   mem_rdata      : read data, valid two cycles after the read cycle
// Protocol: there is no valid/ready pair. Every cycle in which the controller
// is running is exactly one memory operation. The memory never stalls. It
// registers mem_wdata each cycle and uses the registered value for a write
// issued in the following cycle. Read data returns with a fixed two-cycle
// latency.
// Modports: master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface mbist_march_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  mem_write_read;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_write_read, mem_address, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_write_read, mem_address, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// mbist_march_ctrl
// March C- memory BIST controller for addresses 0..CAPACITY.
//   E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 down(r0,w1) E4 down(r1,w0) E5 up(r0)
// Ports:
//   clk, rst_n     : clock (rising edge), async active-low reset
//   start          : one-cycle pulse, accepted only in IDLE or DONE
//   busy / done    : test running / test finished (held until next start)
//   fail, fail_count (saturating), fail_addr, fail_elem, fail_syndrome
//                  : result of the current or last test; the first
//                    miscompare is captured
//   dbg_state      : current FSM state, for observation only
//   mem            : memory bus (master modport)
// ---------------------------------------------------------------------------
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [7:0]            fail_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_syndrome,
    output logic [2:0]            dbg_state,
    mbist_march_if.master         mem
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);
    localparam logic [DATA_WIDTH-1:0] ONES      = {DATA_WIDTH{1'b1}};

    // Elements 3 and 4 walk the address space downwards.
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    // Elements 1..4 are (read, write) pairs; 0 and 5 have a single op.
    function automatic logic elem_two_ops(input logic [2:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    function automatic logic op_is_write(input logic [2:0] e, input logic op);
        return (e == 3'd0) || (op && (e != 3'd5));
    endfunction

    // Data value of an op: write data for writes, expected data for reads.
    function automatic logic op_ones(input logic [2:0] e, input logic op);
        return op ? ((e == 3'd1) || (e == 3'd3)) : ((e == 3'd2) || (e == 3'd4));
    endfunction

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic                  op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  drain_q, drain_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  fail_q, fail_d;
    logic [7:0]            fail_count_q, fail_count_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]            fail_elem_q, fail_elem_d;
    logic [DATA_WIDTH-1:0] fail_syn_q, fail_syn_d;

    // Two-stage read pipeline matching the memory read latency.
    logic                  p1_vld_q, p2_vld_q;
    logic [DATA_WIDTH-1:0] p1_exp_q, p2_exp_q;
    logic [ADDR_WIDTH-1:0] p1_addr_q, p2_addr_q;
    logic [2:0]            p1_elem_q, p2_elem_q;

    logic                  run;
    logic                  cur_write;
    logic                  elem_at_end;
    logic                  nxt_write;
    logic [DATA_WIDTH-1:0] syndrome;
    logic                  miscmp;

    assign run         = (state_q == S_RUN);
    assign cur_write   = op_is_write(elem_q, op_q);
    assign elem_at_end = elem_down(elem_q) ? (addr_q == '0) : (addr_q == LAST_ADDR);
    assign syndrome    = p2_exp_q ^ mem.mem_rdata;
    assign miscmp      = p2_vld_q && (syndrome != '0);

    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        op_d         = op_q;
        addr_d       = addr_q;
        drain_d      = drain_q;
        fail_d       = fail_q;
        fail_count_d = fail_count_q;
        fail_addr_d  = fail_addr_q;
        fail_elem_d  = fail_elem_q;
        fail_syn_d   = fail_syn_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_PREP;
                    fail_d       = 1'b0;
                    fail_count_d = '0;
                    fail_addr_d  = '0;
                    fail_elem_d  = '0;
                    fail_syn_d   = '0;
                end
            end
            S_PREP: begin
                state_d = S_RUN;
                elem_d  = 3'd0;
                op_d    = 1'b0;
                addr_d  = '0;
            end
            S_RUN: begin
                if (elem_two_ops(elem_q) && !op_q) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (!elem_at_end) begin
                        addr_d = elem_down(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
                    end else if (elem_q == 3'd5) begin
                        state_d = S_DRAIN;
                        drain_d = 1'b0;
                    end else begin
                        // Next element starts at its own end of the range.
                        elem_d = elem_q + 3'd1;
                        addr_d = elem_down(elem_q + 3'd1) ? LAST_ADDR : '0;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q) state_d = S_DONE;
                else         drain_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Pipeline is empty in IDLE/DONE, so this never collides with the
        // clear on an accepted start.
        if (miscmp) begin
            if (!fail_q) begin
                fail_addr_d = p2_addr_q;
                fail_elem_d = p2_elem_q;
                fail_syn_d  = syndrome;
            end
            fail_d = 1'b1;
            if (fail_count_q != 8'hFF) fail_count_d = fail_count_q + 8'd1;
        end

        // Write data leads the write by one cycle; hold it otherwise.
        nxt_write = (state_d == S_RUN) && op_is_write(elem_d, op_d);
        wdata_d   = nxt_write ? (op_ones(elem_d, op_d) ? ONES : '0) : wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            elem_q       <= '0;
            op_q         <= 1'b0;
            addr_q       <= '0;
            drain_q      <= 1'b0;
            wdata_q      <= '0;
            fail_q       <= 1'b0;
            fail_count_q <= '0;
            fail_addr_q  <= '0;
            fail_elem_q  <= '0;
            fail_syn_q   <= '0;
            p1_vld_q     <= 1'b0;
            p1_exp_q     <= '0;
            p1_addr_q    <= '0;
            p1_elem_q    <= '0;
            p2_vld_q     <= 1'b0;
            p2_exp_q     <= '0;
            p2_addr_q    <= '0;
            p2_elem_q    <= '0;
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            drain_q      <= drain_d;
            wdata_q      <= wdata_d;
            fail_q       <= fail_d;
            fail_count_q <= fail_count_d;
            fail_addr_q  <= fail_addr_d;
            fail_elem_q  <= fail_elem_d;
            fail_syn_q   <= fail_syn_d;
            p1_vld_q     <= run && !cur_write;
            p1_exp_q     <= op_ones(elem_q, op_q) ? ONES : '0;
            p1_addr_q    <= addr_q;
            p1_elem_q    <= elem_q;
            p2_vld_q     <= p1_vld_q;
            p2_exp_q     <= p1_exp_q;
            p2_addr_q    <= p1_addr_q;
            p2_elem_q    <= p1_elem_q;
        end
    end

    assign busy               = (state_q == S_PREP) || run || (state_q == S_DRAIN);
    assign done               = (state_q == S_DONE);
    assign fail               = fail_q;
    assign fail_count         = fail_count_q;
    assign fail_addr          = fail_addr_q;
    assign fail_elem          = fail_elem_q;
    assign fail_syndrome      = fail_syn_q;
    assign dbg_state          = state_q;
    assign mem.mem_write_read = run && cur_write;
    assign mem.mem_address    = run ? addr_q : '0;
    assign mem.mem_wdata      = wdata_d;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
module tb_mbist_march_ctrl;

  typedef struct packed {
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
  } op_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: 16 x 8 ----------------
  logic       start;
  logic       busy, done, fail;
  logic [7:0] fail_count;
  logic [3:0] fail_addr;
  logic [2:0] fail_elem;
  logic [7:0] fail_syndrome;
  logic [2:0] dbg_state;

  mbist_march_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) mif ();

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .fail(fail), .fail_count(fail_count), .fail_addr(fail_addr),
    .fail_elem(fail_elem), .fail_syndrome(fail_syndrome),
    .dbg_state(dbg_state), .mem(mif)
  );

  // ---------------- DUT B: single word ----------------
  logic       start1;
  logic       busy1, done1, fail1;
  logic [7:0] fail_count1;
  logic [0:0] fail_addr1;
  logic [2:0] fail_elem1;
  logic [7:0] fail_syndrome1;
  logic [2:0] dbg_state1;

  mbist_march_if #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) mif1 ();

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .CAPACITY(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .fail(fail1), .fail_count(fail_count1), .fail_addr(fail_addr1),
    .fail_elem(fail_elem1), .fail_syndrome(fail_syndrome1),
    .dbg_state(dbg_state1), .mem(mif1)
  );

  // ---------------- memory models with read faults ----------------
  logic [7:0] mem_a [16];
  logic [7:0] wd_a, r1_a, rd_a;
  logic       flt_en;
  logic [3:0] flt_addr;
  logic [7:0] flt_sa0, flt_sa1;

  always @(posedge clk) begin
    wd_a <= mif.mem_wdata;
    if (mif.mem_write_read) mem_a[mif.mem_address] <= wd_a;
    else if (flt_en && mif.mem_address == flt_addr)
      r1_a <= (mem_a[mif.mem_address] & ~flt_sa0) | flt_sa1;
    else r1_a <= mem_a[mif.mem_address];
    rd_a <= r1_a;
  end
  assign mif.mem_rdata = rd_a;

  logic [7:0] mem_b [2];
  logic [7:0] wd_b, r1_b, rd_b;
  logic [7:0] flt1_sa1;
  int         wr_cnt1;
  initial wr_cnt1 = 0;

  always @(posedge clk) begin
    wd_b <= mif1.mem_wdata;
    if (mif1.mem_write_read) begin
      mem_b[mif1.mem_address] <= wd_b;
      wr_cnt1 = wr_cnt1 + 1;
    end else r1_b <= mem_b[mif1.mem_address] | flt1_sa1;
    rd_b <= r1_b;
  end
  assign mif1.mem_rdata = rd_b;

  // ---------------- scoreboard / reference model ----------------
  int  n_checks = 0;
  int  n_errors = 0;
  op_t exp_trace[$];
  logic       e_fail;
  logic [7:0] e_cnt;
  logic [3:0] e_addr;
  logic [2:0] e_elem;
  logic [7:0] e_syn;

  int march_nops [6] = '{1, 2, 2, 2, 2, 1};
  bit march_down [6] = '{0, 0, 0, 1, 1, 0};
  bit march_wr   [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
  bit march_val  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walk March C- over an ideal array, faults applied on read.
  task automatic build_model();
    logic [7:0] m [16];
    logic [7:0] v, rd;
    int a;
    exp_trace.delete();
    e_fail = 0; e_cnt = 0; e_addr = 0; e_elem = 0; e_syn = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 16; i++) begin
        a = march_down[e] ? 15 - i : i;
        for (int o = 0; o < march_nops[e]; o++) begin
          v = march_val[e][o] ? 8'hFF : 8'h00;
          if (march_wr[e][o]) begin
            m[a] = v;
            exp_trace.push_back({1'b1, 4'(a), v});
          end else begin
            rd = m[a];
            if (flt_en && 4'(a) == flt_addr) rd = (rd & ~flt_sa0) | flt_sa1;
            exp_trace.push_back({1'b0, 4'(a), 8'h00});
            if (rd != v) begin
              if (!e_fail) begin
                e_addr = 4'(a); e_elem = 3'(e); e_syn = rd ^ v;
              end
              e_fail = 1'b1;
              if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
            end
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_all_zero(input string tag);
    chk(tag, {busy, done, fail, fail_count, fail_addr, fail_elem, fail_syndrome,
              mif.mem_write_read, mif.mem_address, mif.mem_wdata}, 64'h0);
  endtask

  task automatic run_a(input string tag, input int start_at, input int abort_at);
    logic [7:0] wd_prev;
    op_t obs;
    build_model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, " prep"}, {busy, done, fail, fail_count}, {1'b1, 1'b0, 1'b0, 8'h00});
    wd_prev = mif.mem_wdata;
    for (int k = 0; k < exp_trace.size(); k++) begin
      @(negedge clk);
      start = (k == start_at);
      obs.w = mif.mem_write_read;
      obs.a = mif.mem_address;
      obs.d = mif.mem_write_read ? wd_prev : 8'h00;
      chk($sformatf("%s op%0d", tag, k), {busy, done, obs}, {2'b10, exp_trace[k]});
      wd_prev = mif.mem_wdata;
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero({tag, " abort"});
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk({tag, " drain"}, {busy, done}, 2'b10);
    end
    @(negedge clk);
    chk({tag, " done"}, {busy, done}, 2'b01);
    chk({tag, " result"}, {fail, fail_count, fail_addr, fail_elem, fail_syndrome},
        {e_fail, e_cnt, e_addr, e_elem, e_syn});
  endtask

  task automatic run_b(input string tag);
    int cyc, w0;
    w0 = wr_cnt1;
    cyc = -1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done1) begin cyc = i; break; end
    end
    chk({tag, " latency"}, cyc, 13);
    chk({tag, " writes"}, wr_cnt1 - w0, 5);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    flt_en = 1'b0; flt_addr = 0; flt_sa0 = 0; flt_sa1 = 0; flt1_sa1 = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset A");
    chk("reset B", {busy1, done1, fail1, fail_count1}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fault-free run with a start pulse mid-RUN that must be ignored.
    run_a("clean", 50, -1);
    chk("clean result", {fail, fail_count}, 9'h000);

    flt_en = 1'b1; flt_addr = 4'd5; flt_sa0 = 8'h08; flt_sa1 = 8'h00;
    run_a("sa0_a5b3", -1, -1);
    chk("sa0_a5b3 spec", {fail, fail_count, fail_addr, fail_elem, fail_syndrome},
        {1'b1, 8'd2, 4'd5, 3'd2, 8'h08});

    flt_addr = 4'd9; flt_sa0 = 8'h00; flt_sa1 = 8'hFF;
    run_a("sa1_a9", -1, -1);
    chk("sa1_a9 spec", {fail, fail_count, fail_addr, fail_elem, fail_syndrome},
        {1'b1, 8'd3, 4'd9, 3'd1, 8'hFF});

    flt_en = 1'b0;
    run_a("rerun", -1, -1);
    chk("rerun spec", {fail, fail_count}, 9'h000);

    // Reset in the middle of E3 with a fault already recorded.
    flt_en = 1'b1; flt_addr = 4'd3; flt_sa1 = 8'h01;
    run_a("abort", -1, 85);
    repeat (5) @(negedge clk);
    chk("post abort idle", {busy, done, fail, fail_count}, 0);

    for (int r = 0; r < 6; r++) begin
      flt_en   = ($urandom_range(0, 3) != 0);
      flt_addr = 4'($urandom_range(0, 15));
      flt_sa0  = 8'($urandom_range(0, 255));
      flt_sa1  = 8'($urandom_range(0, 255)) & ~flt_sa0;
      run_a($sformatf("rand%0d", r), -1, -1);
    end

    // Single-word configuration.
    run_b("n1 clean");
    chk("n1 clean result", {fail1, fail_count1}, 9'h000);
    flt1_sa1 = 8'hFF;
    run_b("n1 sa1");
    chk("n1 sa1 result", {fail1, fail_count1, fail_addr1, fail_elem1, fail_syndrome1},
        {1'b1, 8'd3, 1'b0, 3'd1, 8'hFF});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, memory address width.
REQ-003 SHALL have parameter CAPACITY, default 15, highest tested address; addresses 0..CAPACITY, N = CAPACITY+1.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse to begin a test.
REQ-007 SHALL have port busy  output  1  test in progress.
REQ-008 SHALL have port done  output  1  test finished; held until next accepted start.
REQ-009 SHALL have port fail  output  1  at least one miscompare in current/last test.
REQ-010 SHALL have port fail_count  output  8  miscompare count, saturating at 255.
REQ-011 SHALL have port fail_addr  output  ADDR_WIDTH  address of first miscompare.
REQ-012 SHALL have port fail_elem  output  3  March element index (0..5) of first miscompare.
REQ-013 SHALL have port fail_syndrome  output  DATA_WIDTH  expected XOR read data of first miscompare.
REQ-014 SHALL have port mem_write_read  output  1  1 = write, 0 = read, to memory under test.
REQ-015 SHALL have port mem_address  output  ADDR_WIDTH  memory address.
REQ-016 SHALL have port mem_wdata  output  DATA_WIDTH  memory write data.
REQ-017 SHALL have port mem_rdata  input  DATA_WIDTH  memory read data.

Function
REQ-018 SHALL run March C-: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0); 0 = all-zeros word, 1 = all-ones word.
REQ-019 SHALL issue one memory operation per cycle; within an element both ops hit one address before stepping; total 10N op cycles.
REQ-020 SHALL use FSM IDLE -> PREP (1 cycle) -> RUN (10N cycles) -> DRAIN (2 cycles) -> DONE; DONE -> PREP on start.
REQ-021 SHALL accept start only in IDLE or DONE; start while busy ignored.
REQ-022 SHALL clear fail, fail_count, fail_addr, fail_elem, fail_syndrome, done on accepted start.
REQ-023 SHALL drive mem_wdata one cycle ahead: value in cycle t equals data of the write issued in cycle t+1 (memory registers write data); PREP preloads all-zeros for E0.
REQ-024 SHALL hold mem_wdata when no write follows.
REQ-025 SHALL compare read data 2 cycles after the read cycle (memory read latency 2) against a 2-stage pipeline of expected data, address, element, valid.
REQ-026 SHALL compare only for pipelined read ops; write cycles produce no compare.
REQ-027 SHALL capture fail_addr/fail_elem/fail_syndrome only on the first miscompare; later miscompares only increment fail_count.
REQ-028 SHALL drive mem_write_read = 0 and mem_address = 0 in IDLE, PREP, DRAIN, DONE.
REQ-029 SHALL assert busy in PREP, RUN, DRAIN; done asserted from DONE entry.
REQ-030 SHALL wrap address up-counter CAPACITY -> 0 and down-counter 0 -> CAPACITY at element boundaries, no extra cycle.
REQ-031 SHALL handle N = 1 (CAPACITY = 0) with same sequence, 10 op cycles.

Reset
REQ-032 SHALL on rst_n low, asynchronously, enter IDLE, clear busy, done, fail, fail_count, fail_addr, fail_elem, fail_syndrome, mem_write_read, mem_address, mem_wdata, pipeline valids.
REQ-033 SHALL abort any test on reset mid-run; no result retained; next test needs new start.

Verification
REQ-034 Fault-free 16x8 memory, start pulse -> done rises 163 cycles after start (1+160+2), fail=0, fail_count=0.
REQ-035 Bit 3 of address 5 stuck-at-0 -> fail=1, fail_addr=5, fail_elem=2, fail_syndrome=0x08, fail_count=2.
REQ-036 Address 9 all bits stuck-at-1 -> fail_elem=1, fail_addr=9, fail_syndrome=0xFF, fail_count=3.
REQ-037 Trace check: cycle after PREP issues write addr 0 data 0x00; first E1 cycles read 0, write 0 with 0xFF; E3 starts at addr 15.
REQ-038 Start asserted mid-RUN -> ignored, sequence unchanged; rst_n low mid-E3 -> all outputs 0 same cycle, IDLE.
REQ-039 Second start after DONE with fault removed -> fail cleared, second run passes.
